bp_update_controller: RTL and testbench
=======================================

# bp_update_controller

Branch-resolution and update controller that sits directly upstream of the 8-entry branch target table. It accepts resolved branches from the execute stage, looks up whether the branch PC already has a table entry, and decides whether to rewrite that entry or allocate a new one. It then drives the table's write port for one cycle. In parallel it raises a one-cycle redirect with the corrected next PC whenever the fetch-time prediction was wrong.

## Interface
- PC_W, 16, PC / target width
- ENTRIES, 8, table entries (power of two)
- IDX_W, 3, log2(ENTRIES)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- ex_valid  in  1  execute-stage instruction valid
- ex_is_branch  in  1  instruction is a conditional branch
- ex_pc  in  PC_W  branch PC
- ex_taken  in  1  resolved direction
- ex_target  in  PC_W  resolved target
- ex_pred_taken  in  1  history bit read from the table at fetch
- ex_pred_target  in  PC_W  BTA read from the table at fetch
- ex_ready  out  1  controller can accept a branch this cycle
- add_BP_lookup  in  IDX_W  table's match index for PC_BP_wr (0 on miss)
- PC_BP_wr  out  PC_W  PC to the table (lookup and write)
- BTA_BP_wr  out  PC_W  BTA to write
- H_BP_wr  out  1  history bit to write
- add_BP_wr  out  IDX_W  entry index to write
- BP_write_enable  out  1  table write strobe
- redirect_valid  out  1  mispredict flush pulse
- redirect_pc  out  PC_W  correct next PC

## Operation
- FSM states:
  - IDLE: ex_ready=1. On accept (ex_valid & ex_is_branch), capture ex_* into r_* and go to LOOKUP. Non-branch valid instructions are ignored.
  - LOOKUP: ex_ready=0. PC_BP_wr=r_pc. Evaluate hit, compute the write decision into w_* registers, go to WRITE if a write is needed, else IDLE.
  - WRITE: ex_ready=0. BP_write_enable=1, PC_BP_wr=w_pc. Update valid bits and the allocation pointer. Go to IDLE.
- Mispredict: mp = (r_taken != r_pred_taken) | (r_taken & r_pred_taken & r_target != r_pred_target). Computed at accept and registered.
- redirect_pc = taken ? target : pc + 1 (mod 2^PC_W; PC 0xFFFF wraps to 0x0000).
- Internal state:
  - valid[ENTRIES-1:0]: cleared by reset.
  - pc0_shadow: copy of the PC last written to entry 0.
  - alloc_ptr: IDX_W bits, reset 0.
- Hit:
  - If add_BP_lookup != 0, hit = valid[add_BP_lookup].
  - Otherwise hit = valid[0] & (pc0_shadow == r_pc). This disambiguates the table's "0 means miss" encoding.
  - A non-binary (X) add_BP_lookup is treated as a miss.
- Write decision:
  - hit & mp: write add=add_BP_lookup, H=r_taken, BTA = r_taken ? r_target : r_pred_target.
  - miss & r_taken: allocate add=alloc_ptr, H=1, BTA=r_target. alloc_ptr increments in WRITE and wraps 7→0. The pointer advances only on allocation, never on a hit update.
  - hit & !mp, or miss & !r_taken: no write.
- WRITE sets valid[add]=1 and loads pc0_shadow when add==0.
- No duplicate entries: allocation happens only on a miss.

## Timing
- Cycle 0: accept. Cycle 1: LOOKUP, redirect_valid=1 for exactly this cycle if mp. Cycle 2: WRITE (BP_write_enable=1). The table latches at the end of cycle 2.
- Back-to-back branches: ex_ready is low in LOOKUP and WRITE, so the execute stage holds. The next accept occurs in the first IDLE cycle.
- Minimum spacing: 2 cycles without a write, 3 cycles with one.
- A lookup after a write sees the updated table, because the write completes before the state returns to IDLE.
- Reset values: ex_ready=1, BP_write_enable=0, redirect_valid=0, redirect_pc=0, PC_BP_wr=0, BTA_BP_wr=0, H_BP_wr=0, add_BP_wr=0, state=IDLE, valid=0, alloc_ptr=0, pc0_shadow=0.
- Reset mid-operation: asynchronous abort. BP_write_enable and redirect_valid drop immediately and any pending write is discarded. Table contents persist but are ignored because valid=0.
- BP_write_enable is registered and is never high for more than one consecutive cycle.

## Test plan
- After reset, branch pc=0x0010 taken to target 0x0040, pred 0/0x0000 → redirect_valid in cycle 1 with redirect_pc=0x0040; cycle 2 writes add=0, H=1, BTA=0x0040; alloc_ptr=1.
- Same pc=0x0010 taken, pred 1/0x0040, add_BP_lookup=0 → pc0_shadow gives hit, no mispredict: no redirect, no write; ex_ready returns high in cycle 2.
- pc=0x0010 not taken, pred 1/0x0040 → redirect_pc=0x0011; write add=0, H=0, BTA=0x0040.
- Nine taken misses with distinct PCs 0x0100..0x0108 → writes go to add 1..7, then 0 (wrap), then 1. ex_ready low 2 cycles per branch.
- Not-taken miss pc=0x0200 with pred 0 → no redirect, no write. pc=0xFFFF not taken with pred 1 → redirect_pc=0x0000.
- Assert reset during WRITE → BP_write_enable falls asynchronously and valid clears. A following hit-looking lookup of a previously written PC is treated as a miss.

Source files
------------

// File: rtl/bp_update_controller.sv
// Branch-resolution / update controller feeding an 8-entry branch target table.
// Accepts a resolved branch, looks up its table entry, decides between rewriting
// a hit entry or allocating a new one, and pulses a redirect on a mispredict.
module bp_update_controller #(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_pred_target,
    output logic             ex_ready,
    input  logic [IDX_W-1:0] add_BP_lookup,
    output logic [PC_W-1:0]  PC_BP_wr,
    output logic [PC_W-1:0]  BTA_BP_wr,
    output logic             H_BP_wr,
    output logic [IDX_W-1:0] add_BP_wr,
    output logic             BP_write_enable,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t             r_state;

    // Captured branch
    logic [PC_W-1:0]    r_pc;
    logic               r_taken;
    logic [PC_W-1:0]    r_target;
    logic               r_pred_target_unused_guard;
    logic [PC_W-1:0]    r_pred_target;
    logic               r_mp;

    // Table bookkeeping
    logic [ENTRIES-1:0] r_valid;
    logic [PC_W-1:0]    r_pc0_shadow;
    logic [IDX_W-1:0]   r_alloc_ptr;
    logic               r_alloc;

    // Combinational helpers
    logic               w_accept;
    logic               w_mp;
    logic [PC_W-1:0]    w_redirect_pc;
    logic               w_hit;
    logic               w_wr_needed;
    logic               w_wr_alloc;
    logic [IDX_W-1:0]   w_wr_add;
    logic               w_wr_h;
    logic [PC_W-1:0]    w_wr_bta;

    assign w_accept      = ex_valid & ex_is_branch;
    assign w_mp          = (ex_taken != ex_pred_taken) |
                           (ex_taken & ex_pred_taken & (ex_target != ex_pred_target));
    assign w_redirect_pc = ex_taken ? ex_target : (ex_pc + PC_W'(1));

    // Hit detection; index 0 doubles as the table's miss code, so entry 0 is
    // confirmed against the shadow copy of the PC last written there
    always_comb begin
        w_hit = 1'b0;
        if (!$isunknown(add_BP_lookup)) begin
            if (add_BP_lookup != '0)
                w_hit = r_valid[add_BP_lookup];
            else
                w_hit = r_valid[0] & (r_pc0_shadow == r_pc);
        end
    end

    // Write decision: rewrite a mispredicted hit, allocate on a taken miss
    always_comb begin
        w_wr_needed = 1'b0;
        w_wr_alloc  = 1'b0;
        w_wr_add    = '0;
        w_wr_h      = 1'b0;
        w_wr_bta    = '0;
        if (w_hit && r_mp) begin
            w_wr_needed = 1'b1;
            w_wr_add    = add_BP_lookup;
            w_wr_h      = r_taken;
            w_wr_bta    = r_taken ? r_target : r_pred_target;
        end else if (!w_hit && r_taken) begin
            w_wr_needed = 1'b1;
            w_wr_alloc  = 1'b1;
            w_wr_add    = r_alloc_ptr;
            w_wr_h      = 1'b1;
            w_wr_bta    = r_target;
        end
    end

    // Controller FSM with registered outputs and table bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state                    <= ST_IDLE;
            r_pc                       <= '0;
            r_taken                    <= 1'b0;
            r_target                   <= '0;
            r_pred_target_unused_guard <= 1'b0;
            r_pred_target              <= '0;
            r_mp                       <= 1'b0;
            r_valid                    <= '0;
            r_pc0_shadow               <= '0;
            r_alloc_ptr                <= '0;
            r_alloc                    <= 1'b0;
            ex_ready                   <= 1'b1;
            PC_BP_wr                   <= '0;
            BTA_BP_wr                  <= '0;
            H_BP_wr                    <= 1'b0;
            add_BP_wr                  <= '0;
            BP_write_enable            <= 1'b0;
            redirect_valid             <= 1'b0;
            redirect_pc                <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pc                       <= ex_pc;
                        r_taken                    <= ex_taken;
                        r_target                   <= ex_target;
                        r_pred_target_unused_guard <= ex_pred_taken;
                        r_pred_target              <= ex_pred_target;
                        r_mp                       <= w_mp;
                        redirect_valid             <= w_mp;
                        redirect_pc                <= w_redirect_pc;
                        PC_BP_wr                   <= ex_pc;
                        ex_ready                   <= 1'b0;
                        r_state                    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    redirect_valid <= 1'b0;
                    if (w_wr_needed) begin
                        BP_write_enable <= 1'b1;
                        PC_BP_wr        <= r_pc;
                        add_BP_wr       <= w_wr_add;
                        H_BP_wr         <= w_wr_h;
                        BTA_BP_wr       <= w_wr_bta;
                        r_alloc         <= w_wr_alloc;
                        r_state         <= ST_WRITE;
                    end else begin
                        ex_ready <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    BP_write_enable     <= 1'b0;
                    r_valid[add_BP_wr]  <= 1'b1;
                    if (add_BP_wr == '0)
                        r_pc0_shadow <= PC_BP_wr;
                    if (r_alloc)
                        r_alloc_ptr <= r_alloc_ptr + IDX_W'(1);
                    r_alloc  <= 1'b0;
                    ex_ready <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    BP_write_enable <= 1'b0;
                    redirect_valid  <= 1'b0;
                    ex_ready        <= 1'b1;
                    r_state         <= ST_IDLE;
                end
            endcase
        end
    end

    // The captured prediction direction only matters through r_mp
    logic w_unused;
    assign w_unused = r_pred_target_unused_guard;

endmodule

// File: tb/tb_bp_update_controller.sv
// Self-checking bench for bp_update_controller: a small branch-target-table
// model answers lookups and latches writes; branches are applied from a vector
// table with hand-computed expectations, plus hand-written corner sequences.
module tb_bp_update_controller;

    localparam int PC_W  = 16;
    localparam int IDX_W = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             ex_valid = 1'b0;
    logic             ex_is_branch = 1'b0;
    logic [PC_W-1:0]  ex_pc = '0;
    logic             ex_taken = 1'b0;
    logic [PC_W-1:0]  ex_target = '0;
    logic             ex_pred_taken = 1'b0;
    logic [PC_W-1:0]  ex_pred_target = '0;
    logic             ex_ready;
    logic [IDX_W-1:0] add_BP_lookup;
    logic [PC_W-1:0]  PC_BP_wr;
    logic [PC_W-1:0]  BTA_BP_wr;
    logic             H_BP_wr;
    logic [IDX_W-1:0] add_BP_wr;
    logic             BP_write_enable;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    bp_update_controller #(.PC_W(16), .ENTRIES(8), .IDX_W(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_ready       (ex_ready),
        .add_BP_lookup  (add_BP_lookup),
        .PC_BP_wr       (PC_BP_wr),
        .BTA_BP_wr      (BTA_BP_wr),
        .H_BP_wr        (H_BP_wr),
        .add_BP_wr      (add_BP_wr),
        .BP_write_enable(BP_write_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clock = ~clock;

    // Table model: contents survive controller reset
    logic [PC_W-1:0] tab_pc [8];
    logic            tab_v  [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            tab_pc[i] = '0;
            tab_v[i]  = 1'b0;
        end
    end

    always @(posedge clock) begin
        if (BP_write_enable) begin
            tab_pc[add_BP_wr] <= PC_BP_wr;
            tab_v[add_BP_wr]  <= 1'b1;
        end
    end

    always_comb begin
        add_BP_lookup = '0;
        for (int i = 0; i < 8; i++)
            if (tab_v[i] && tab_pc[i] == PC_BP_wr)
                add_BP_lookup = IDX_W'(i);
    end

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic             taken;
        logic [PC_W-1:0]  target;
        logic             pred_taken;
        logic [PC_W-1:0]  pred_target;
        logic             exp_redir;
        logic [PC_W-1:0]  exp_rpc;
        logic             exp_wr;
        logic [IDX_W-1:0] exp_add;
        logic             exp_h;
        logic [PC_W-1:0]  exp_bta;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(logic [15:0] pc, logic tk, logic [15:0] tg,
                                 logic ptk, logic [15:0] ptg, logic er,
                                 logic [15:0] erpc, logic ew, logic [2:0] ea,
                                 logic eh, logic [15:0] ebta);
        vec_t v;
        v.pc = pc; v.taken = tk; v.target = tg; v.pred_taken = ptk;
        v.pred_target = ptg; v.exp_redir = er; v.exp_rpc = erpc;
        v.exp_wr = ew; v.exp_add = ea; v.exp_h = eh; v.exp_bta = ebta;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Wait (bounded) for ex_ready at a falling edge
    task automatic wait_ready(input string tag, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (ex_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_ready_timeout"}, 32'(ex_ready), 32'd1);
    endtask

    // Accept a branch at the current falling edge (controller idle)
    task automatic drive_branch(input vec_t v);
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b1;
        ex_pc          = v.pc;
        ex_taken       = v.taken;
        ex_target      = v.target;
        ex_pred_taken  = v.pred_taken;
        ex_pred_target = v.pred_target;
        @(posedge clock);
        #1;
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
    endtask

    task automatic do_branch(input string tag, input vec_t v);
        bit ok;
        wait_ready(tag, ok);
        if (!ok) return;
        drive_branch(v);
        // Cycle 1: lookup
        @(negedge clock);
        check({tag, "_c1_ready"}, 32'(ex_ready), 32'd0);
        check({tag, "_c1_redir"}, 32'(redirect_valid), 32'(v.exp_redir));
        if (v.exp_redir) check({tag, "_c1_rpc"}, 32'(redirect_pc), 32'(v.exp_rpc));
        check({tag, "_c1_we"}, 32'(BP_write_enable), 32'd0);
        check({tag, "_c1_pcwr"}, 32'(PC_BP_wr), 32'(v.pc));
        // Cycle 2: write or back to idle
        @(negedge clock);
        check({tag, "_c2_redir"}, 32'(redirect_valid), 32'd0);
        check({tag, "_c2_we"}, 32'(BP_write_enable), 32'(v.exp_wr));
        if (v.exp_wr) begin
            check({tag, "_c2_ready"}, 32'(ex_ready), 32'd0);
            check({tag, "_c2_add"}, 32'(add_BP_wr), 32'(v.exp_add));
            check({tag, "_c2_h"}, 32'(H_BP_wr), 32'(v.exp_h));
            check({tag, "_c2_bta"}, 32'(BTA_BP_wr), 32'(v.exp_bta));
            check({tag, "_c2_pcwr"}, 32'(PC_BP_wr), 32'(v.pc));
            @(negedge clock);
            check({tag, "_c3_ready"}, 32'(ex_ready), 32'd1);
            check({tag, "_c3_we"}, 32'(BP_write_enable), 32'd0);
        end else begin
            check({tag, "_c2_ready"}, 32'(ex_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit ok;

        // Directed vectors: pc, tk, tgt, ptk, ptgt | redir, rpc, wr, add, h, bta
        vq.push_back(mkv(16'h0010, 1, 16'h0040, 0, 16'h0000, 1, 16'h0040, 1, 3'd0, 1, 16'h0040));
        vq.push_back(mkv(16'h0010, 1, 16'h0040, 1, 16'h0040, 0, 16'h0000, 0, 3'd0, 0, 16'h0000));
        vq.push_back(mkv(16'h0010, 0, 16'h0040, 1, 16'h0040, 1, 16'h0011, 1, 3'd0, 0, 16'h0040));
        for (int k = 0; k < 9; k++)
            vq.push_back(mkv(16'h0100 + 16'(k), 1, 16'h1000 + 16'(k), 0, 16'h0000,
                             1, 16'h1000 + 16'(k), 1, 3'((k + 1) % 8), 1, 16'h1000 + 16'(k)));
        vq.push_back(mkv(16'h0200, 0, 16'h0300, 0, 16'h0000, 0, 16'h0000, 0, 3'd0, 0, 16'h0000));
        vq.push_back(mkv(16'hFFFF, 0, 16'h1234, 1, 16'h1234, 1, 16'h0000, 0, 3'd0, 0, 16'h0000));
        // Hit with wrong target rewrites entry 4 without moving the pointer
        vq.push_back(mkv(16'h0103, 1, 16'h2222, 1, 16'h1003, 1, 16'h2222, 1, 3'd4, 1, 16'h2222));
        vq.push_back(mkv(16'h0300, 1, 16'h3300, 0, 16'h0000, 1, 16'h3300, 1, 3'd2, 1, 16'h3300));

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", 32'(ex_ready), 32'd1);
        check("rst_we", 32'(BP_write_enable), 32'd0);
        check("rst_redir", 32'(redirect_valid), 32'd0);
        check("rst_rpc", 32'(redirect_pc), 32'd0);
        check("rst_pcwr", 32'(PC_BP_wr), 32'd0);
        check("rst_bta", 32'(BTA_BP_wr), 32'd0);
        check("rst_h", 32'(H_BP_wr), 32'd0);
        check("rst_add", 32'(add_BP_wr), 32'd0);

        // Non-branch valid instruction is ignored
        ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = 16'h0777;
        ex_taken = 1'b1; ex_target = 16'h0999; ex_pred_taken = 1'b0;
        @(posedge clock);
        #1 ex_valid = 1'b0;
        @(negedge clock);
        check("nonbr_ready", 32'(ex_ready), 32'd1);
        check("nonbr_redir", 32'(redirect_valid), 32'd0);
        check("nonbr_pcwr", 32'(PC_BP_wr), 32'd0);

        // Vector table
        foreach (vq[i]) do_branch($sformatf("v%0d", i), vq[i]);

        // Reset asserted during WRITE discards the write and clears valid bits
        wait_ready("rstw", ok);
        if (ok) begin
            v = mkv(16'h0400, 1, 16'h4400, 0, 16'h0000, 1, 16'h4400, 1, 3'd3, 1, 16'h4400);
            drive_branch(v);
            @(negedge clock);
            check("rstw_c1_redir", 32'(redirect_valid), 32'd1);
            @(negedge clock);
            check("rstw_c2_we", 32'(BP_write_enable), 32'd1);
            check("rstw_c2_add", 32'(add_BP_wr), 32'd3);
            reset = 1'b1;
            #1;
            check("rstw_async_we", 32'(BP_write_enable), 32'd0);
            check("rstw_async_ready", 32'(ex_ready), 32'd1);
            check("rstw_async_redir", 32'(redirect_valid), 32'd0);
            check("rstw_async_add", 32'(add_BP_wr), 32'd0);
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            check("rstw_no_stale_wr", 32'(tab_pc[3]), 32'h0102);
        end

        // Previously written PC (table entry 6) now misses: allocate at 0
        do_branch("post_rst", mkv(16'h0105, 1, 16'h1005, 1, 16'h1005, 0, 16'h0000, 1, 3'd0, 1, 16'h1005));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
